// File: rtl/fixed_linear_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fixed_linear_stream_pkg
// Purpose  : Shared types and helpers for the fixed linear weight streamer.
//            Holds the streamer state encoding and the beat-address mapping.
//            The software-side weight packer uses the same mapping.
// Revision : 1.0 - initial release
// ============================================================================
package fixed_linear_stream_pkg;

    // Streamer control states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } stream_state_t;

    // Storage slot of the beat for (tile, depth).
    // in_depth is the number of beats per accumulation (IN_DEPTH).
    function automatic int unsigned beat_addr(
        input int unsigned tile,
        input int unsigned depth,
        input int unsigned in_depth
    );
        return tile * in_depth + depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_beat_bank.sv
`default_nettype none
// ============================================================================
// Module   : weight_beat_bank
// Purpose  : Register array holding NUM_BEATS beats of WEIGHT_SIZE words.
//            It has one synchronous write port and one asynchronous read port.
//            The array is intentionally not reset, so its contents survive rst.
// Ports    : clk      - clock
//            wr_en    - write strobe, already qualified by the caller
//            wr_addr  - write beat address; out-of-range writes are dropped
//            wr_data  - write beat contents
//            rd_addr  - read beat address
//            rd_data  - read beat contents (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module weight_beat_bank #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int WEIGHT_SIZE  = 8,
    parameter int NUM_BEATS    = 6,
    parameter int ADDR_WIDTH   = 3
) (
    input  logic                                    clk,
    input  logic                                    wr_en,
    input  logic [ADDR_WIDTH-1:0]                   wr_addr,
    input  logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]                   rd_addr,
    output logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(NUM_BEATS);

    logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] r_mem [NUM_BEATS];

    logic w_wr_in_range;
    logic w_rd_in_range;

    // The address may have unused codes when NUM_BEATS is not a power of two
    assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);

    always_ff @(posedge clk) begin
        if (wr_en && w_wr_in_range) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (w_rd_in_range) begin
            rd_data = r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fixed_linear_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module   : fixed_linear_weight_streamer
// Purpose  : Producer of the weight stream consumed by the fixed linear layer.
//            A transposed, partitioned weight matrix sits in a register bank.
//            The bank is loaded through a simple write port while idle.
//            On start, the matrix is replayed 'frames' times as a
//            valid/ready stream of WEIGHT_SIZE-word beats.
//            In beat k, tile = k / IN_DEPTH and depth = k % IN_DEPTH.
// Ports    : clk, rst             - clock, async active-high reset
//            wr_en/wr_addr/wr_data - beat write port (accepted when wr_ready)
//            wr_ready             - high only while idle
//            start, frames        - launch a run of 'frames' matrix replays
//            busy                 - high while a run is in progress
//            done                 - one-cycle pulse on the final handshake
//            weight/weight_valid  - beat stream to the linear layer
//            weight_ready         - downstream ready
// Revision : 1.0 - initial release
// ============================================================================
module fixed_linear_weight_streamer
    import fixed_linear_stream_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 16,
    parameter int IN_SIZE      = 4,
    parameter int IN_DEPTH     = 3,
    parameter int PARALLELISM  = 2,
    parameter int OUT_DEPTH    = 2,
    parameter int WEIGHT_SIZE  = IN_SIZE * PARALLELISM,
    parameter int FRAME_WIDTH  = 8,
    localparam int NUM_BEATS   = OUT_DEPTH * IN_DEPTH,
    localparam int ADDR_WIDTH  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wr_en,
    input  logic [ADDR_WIDTH-1:0]                    wr_addr,
    input  logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] wr_data,
    output logic                                     wr_ready,
    input  logic                                     start,
    input  logic [FRAME_WIDTH-1:0]                   frames,
    output logic                                     busy,
    output logic                                     done,
    output logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] weight,
    output logic                                     weight_valid,
    input  logic                                     weight_ready
);

    localparam logic [ADDR_WIDTH-1:0] c_last_beat =
        ADDR_WIDTH'(beat_addr(OUT_DEPTH - 1, IN_DEPTH - 1, IN_DEPTH));

    stream_state_t                            r_state;
    stream_state_t                            w_next_state;
    logic [ADDR_WIDTH-1:0]                    r_beat;
    logic [FRAME_WIDTH-1:0]                   r_frame;
    logic [FRAME_WIDTH-1:0]                   r_frames;
    logic [FRAME_WIDTH-1:0]                   w_frames_m1;
    logic                                     r_exhausted;
    logic                                     r_valid;
    logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] r_weight;
    logic [WEIGHT_SIZE-1:0][WEIGHT_WIDTH-1:0] w_rd_data;
    logic                                     w_accept;
    logic                                     w_final;
    logic                                     w_load;
    logic                                     w_last_beat;
    logic                                     w_last_frame;
    logic                                     w_wr_en;

    // Writes are accepted only while idle
    assign w_wr_en = wr_en && (r_state == ST_IDLE);

    weight_beat_bank #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .WEIGHT_SIZE  (WEIGHT_SIZE),
        .NUM_BEATS    (NUM_BEATS),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_bank (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (r_beat),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, start acceptance and the load decision for the output register.
    // The accept edge also loads beat 0, so valid appears the cycle after start.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_final      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (frames != '0)) begin
                    w_accept     = 1'b1;
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // r_exhausted means the register holds the last beat of the run
                if (r_valid && weight_ready && r_exhausted) begin
                    w_final      = 1'b1;
                    w_next_state = ST_IDLE;
                end
                w_load = !r_exhausted && (!r_valid || weight_ready);
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // On the accept edge, the frame count comes from the input port, not the latch
    assign w_frames_m1  = (w_accept ? frames : r_frames) - 1'b1;
    assign w_last_beat  = (r_beat == c_last_beat);
    assign w_last_frame = (r_frame == w_frames_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat      <= '0;
            r_frame     <= '0;
            r_frames    <= '0;
            r_exhausted <= 1'b0;
            r_valid     <= 1'b0;
            r_weight    <= '0;
        end else begin
            if (w_accept) begin
                r_frames    <= frames;
                r_exhausted <= 1'b0;
            end
            if (w_load) begin
                r_weight <= w_rd_data;
                r_valid  <= 1'b1;
                if (w_last_beat) begin
                    r_beat <= '0;
                    if (w_last_frame) begin
                        r_exhausted <= 1'b1;
                    end else begin
                        r_frame <= r_frame + 1'b1;
                    end
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end else if (weight_ready) begin
                r_valid <= 1'b0;
            end
            if (w_final) begin
                r_frame     <= '0;
                r_exhausted <= 1'b0;
            end
        end
    end

    assign wr_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign done         = w_final;
    assign weight       = r_weight;
    assign weight_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fixed_linear_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_linear_weight_streamer
// Purpose  : Scoreboard testbench for fixed_linear_weight_streamer.
//            Stimulus pushes the expected beats of each run from a storage model.
//            A negedge monitor pops and compares them on every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_linear_weight_streamer;

    localparam int WW = 16;
    localparam int IN_SIZE = 4;
    localparam int IN_DEPTH = 3;
    localparam int PAR = 2;
    localparam int OUT_DEPTH = 2;
    localparam int WS = IN_SIZE * PAR;
    localparam int FW = 8;
    localparam int NB = OUT_DEPTH * IN_DEPTH;
    localparam int AW = 3;

    typedef logic [WS-1:0][WW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    beat_t         wr_data;
    logic          wr_ready;
    logic          start;
    logic [FW-1:0] frames;
    logic          busy;
    logic          done;
    beat_t         weight;
    logic          weight_valid;
    logic          weight_ready;

    fixed_linear_weight_streamer #(
        .WEIGHT_WIDTH (WW),
        .IN_SIZE      (IN_SIZE),
        .IN_DEPTH     (IN_DEPTH),
        .PARALLELISM  (PAR),
        .OUT_DEPTH    (OUT_DEPTH),
        .FRAME_WIDTH  (FW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .start        (start),
        .frames       (frames),
        .busy         (busy),
        .done         (done),
        .weight       (weight),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready)
    );

    always #5 clk = ~clk;

    beat_t model_mem [NB];
    beat_t exp_q [$];
    int    vec = 0;
    int    errs = 0;
    int    done_seen = 0;
    int    runs_done = 0;
    int    ready_mode = 0;
    bit    stall_pending = 1'b0;
    beat_t stall_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        vec++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Downstream ready: always high, or low about one cycle in three
    initial begin
        weight_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            weight_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: a handshake at the next edge is visible at this negedge
    always @(negedge clk) begin
        if (rst) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check("stall_valid", 128'(weight_valid), 128'(1));
                check("stall_data", weight, stall_data);
            end
            stall_pending = weight_valid && !weight_ready;
            stall_data    = weight;
            if (weight_valid && weight_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    check("beat_data", weight, exp_q.pop_front());
                    check("done_on_beat", 128'(done), 128'(exp_q.size() == 0));
                    if (done) done_seen++;
                end
            end else begin
                check("done_idle", 128'(done), 128'(0));
            end
        end
    end

    task automatic write_beat(input int addr, input beat_t data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        // Spec model: accepted only while idle and in range
        if (wr_ready && addr < NB) model_mem[addr] = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic start_run(input int nf);
        for (int f = 0; f < nf; f++)
            for (int k = 0; k < NB; k++)
                exp_q.push_back(model_mem[k]);
        check("pre_start_valid", 128'(weight_valid), 128'(0));
        start  = 1'b1;
        frames = FW'(nf);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("first_valid", 128'(weight_valid), 128'(1));
        check("busy_run", 128'(busy), 128'(1));
    endtask

    task automatic wait_idle(input int exp_cycles);
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            check("run_timeout", 128'(busy), 128'(0));
        end else begin
            runs_done++;
            if (exp_cycles >= 0) check("run_cycles", 128'(n), 128'(exp_cycles));
            check("idle_valid", 128'(weight_valid), 128'(0));
            check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        end
    endtask

    initial begin
        beat_t d;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; frames = '0;
        #1;
        check("rst_valid", 128'(weight_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_wr_ready", 128'(wr_ready), 128'(1));
        check("rst_weight", weight, 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Word j of beat k = 16*k + j
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < WS; j++) d[j] = WW'(16 * k + j);
            write_beat(k, d);
        end

        ready_mode = 0;
        start_run(1); wait_idle(NB);
        start_run(3); wait_idle(3 * NB);

        ready_mode = 1;
        start_run(2); wait_idle(-1);
        ready_mode = 0;
        @(posedge clk); #1;

        // start with zero frames is ignored
        start = 1'b1; frames = '0;
        @(posedge clk); #1 start = 1'b0;
        check("zero_frames_busy", 128'(busy), 128'(0));
        check("zero_frames_valid", 128'(weight_valid), 128'(0));

        // Write and restart attempts during RUN are ignored
        start_run(1);
        check("wr_ready_run", 128'(wr_ready), 128'(0));
        for (int j = 0; j < WS; j++) d[j] = 16'hFFFF;
        write_beat(0, d);
        start = 1'b1; frames = 8'd5;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(NB - 2);
        start_run(1); wait_idle(NB);

        // Asynchronous reset mid-stream
        start_run(2);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 128'(weight_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        start_run(1); wait_idle(NB);

        // Out-of-range addresses, then random contents under random stalls
        for (int j = 0; j < WS; j++) d[j] = WW'($urandom);
        write_beat(6, d);
        write_beat(7, d);
        start_run(1); wait_idle(NB);
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < WS; j++) d[j] = WW'($urandom);
            write_beat(k, d);
        end
        ready_mode = 1;
        start_run(2); wait_idle(-1);
        ready_mode = 0;
        @(posedge clk); #1;

        check("done_count", 128'(done_seen), 128'(runs_done));
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fixed_linear_weight_streamer.md
Name: fixed_linear_weight_streamer

Overview:
- Producer side of the weight handshake consumed by the fixed linear layer.
- Holds a transposed, partitioned weight matrix in on-chip registers, loaded through a simple write port.
- Replays the matrix as a valid/ready stream of WEIGHT_SIZE-word beats, in the order the linear layer's dot products expect, for a requested number of frames.

Parameters:
- WEIGHT_WIDTH, 16, bits per weight word
- IN_SIZE, 4, words per dot-product input beat
- IN_DEPTH, 3, beats per accumulation (input vector length = IN_SIZE*IN_DEPTH)
- PARALLELISM, 2, output channels per tile
- OUT_DEPTH, 2, output tiles (output channels = PARALLELISM*OUT_DEPTH)
- WEIGHT_SIZE, IN_SIZE*PARALLELISM, words per beat
- FRAME_WIDTH, 8, width of the frame-count input
- Derived localparams: NUM_BEATS = OUT_DEPTH*IN_DEPTH; ADDR_WIDTH = max(1, $clog2(NUM_BEATS))

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  beat address (tile*IN_DEPTH + depth)
- wr_data  in  WEIGHT_WIDTH x WEIGHT_SIZE  beat contents
- wr_ready  out  1  write accepted (high only in IDLE)
- start  in  1  begin streaming (sampled in IDLE)
- frames  in  FRAME_WIDTH  number of full-matrix replays
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse on final handshake
- weight  out  WEIGHT_WIDTH x WEIGHT_SIZE  beat data
- weight_valid  out  1  beat valid
- weight_ready  in  1  downstream ready

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE
  - weight_valid = 0, done = 0, busy = 0, wr_ready = 1
  - beat and frame counters = 0; weight output register = 0
  - Storage array is NOT reset; contents survive rst.
- Reset asserted mid-stream aborts immediately. No done pulse. The next start replays from beat 0.
- Writes: when wr_en && wr_ready, storage[wr_addr] <= wr_data at the clock edge.
  - wr_addr >= NUM_BEATS is dropped.
  - wr_en outside IDLE is ignored.
- States: IDLE, RUN.
  - IDLE -> RUN on start && frames != 0. Latch frames; beat = 0; frame = 0.
  - start with frames == 0 is ignored; stay IDLE.
  - start in RUN is ignored.
- Beat order: beat k has tile t = k / IN_DEPTH and depth d = k % IN_DEPTH, read from storage[k].
  - Word j of the beat = W[t*PARALLELISM + j/IN_SIZE][d*IN_SIZE + j%IN_SIZE].
  - Segment i (words IN_SIZE*i .. IN_SIZE*i+IN_SIZE-1) feeds parallel dot product i.
- Output stage: single register. It loads when (!weight_valid || weight_ready) and beats remain.
  - Combinational read of storage[beat]; beat counter advances on load.
  - First weight_valid rises in the cycle after start is accepted.
  - Full throughput: with weight_ready held high, one beat per cycle, no bubbles, including across frame boundaries.
- Handshake rules:
  - weight and weight_valid are held stable while weight_valid && !weight_ready.
  - weight_valid never drops without a handshake, except on reset.
- Wrap-around: after beat NUM_BEATS-1 is loaded:
  - if frame < frames-1: beat = 0, frame++;
  - otherwise no further loads.
- Completion: the handshake of the final beat of the final frame does all of the following:
  - done = 1 for exactly one cycle;
  - RUN -> IDLE on the same edge, so busy and weight_valid are 0 the next cycle;
  - start in the done cycle is ignored.
- Total beats per run = frames * NUM_BEATS. frames = 2^FRAME_WIDTH-1 must not overflow the counters.

Decomposition:
- Package fixed_linear_stream_pkg holds:
  - the state enum (IDLE, RUN);
  - a function beat_addr(tile, depth) = tile*IN_DEPTH + depth, shared with the software-side weight packer model.
- One sub-module: weight_beat_bank. It holds the NUM_BEATS x WEIGHT_SIZE register array, with the write port and an asynchronous read port.
- FSM, counters and the output register live in the top module.

Test Plan:
- Load beats 0..5 with word j of beat k = 16*k + j (IN_SIZE=4, PARALLELISM=2, IN_DEPTH=3, OUT_DEPTH=2); start, frames=1, ready=1 -> 6 consecutive beats 0..5, valid rising the cycle after start, done on beat 5, busy low next cycle.
- Same load; frames=3, ready=1 -> 18 beats with no bubble; beat 6 equals beat 0; single done pulse on beat 17.
- frames=2, ready toggled pseudo-randomly (1 in 3 low) -> data stable while stalled, all 12 beats delivered in order, no duplicates or drops.
- start with frames=0 -> busy stays 0, no valid. wr_en in RUN to addr 0 with data 0xFFFF -> wr_ready=0, next run still emits the original beat 0.
- Assert rst at beat 3 of frames=2 -> valid/busy/done 0 asynchronously; restart frames=1 emits beat 0 with the pre-reset contents.
- wr_addr=6 (out of range) -> no storage change; a second start during RUN -> ignored, beat count unchanged.
